array_nrp_parity: RTL and testbench

Single-clock register array with a parameterised number of synchronous read ports and per-group parity protection. Each port has its own error flag, and the block keeps sticky error status, a first-error capture and a saturating error counter. It is the next-generation storage primitive for per-channel configuration and state tables that several pipeline stages read in the same wclk domain. It adds error injection and error localisation for CPU diagnostics.

---
 rtl/array_par_pkg.sv | 28 ++
 rtl/array_rdport_chk.sv | 68 ++++++
 rtl/array_nrp_parity.sv | 132 +++++++++++++
 tb/tb_array_nrp_parity.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_par_pkg.sv
// array_par_pkg
//   Shared constants and the parity helper for the parity-protected register
//   array. grp_parity() takes the data zero-extended to MAXW bits plus the
//   real data width and group size, and returns one even-parity bit per
//   group in the low bits. Callers size-cast the result down to their group
//   count.
package array_par_pkg;

  localparam int PIDW  = 4;    // width of the reported port index
  localparam int MAXW  = 256;  // widest data word the helper accepts
  localparam int MAXNG = 256;  // most parity groups the helper returns

  function automatic logic [MAXNG-1:0] grp_parity(input logic [MAXW-1:0] data,
                                                  input int width,
                                                  input int pargrp);
    logic [MAXNG-1:0] p;
    logic [7:0]       idx;
    p = '0;
    for (int i = 0; i < MAXW; i++) begin
      if (i < width) begin
        idx    = 8'(i / pargrp);
        p[idx] = p[idx] ^ data[i];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/array_rdport_chk.sv
// array_rdport_chk
//   One synchronous read port with a parity check on the registered data.
//   Ports:
//     wclk, rst_  clock and async active-low reset
//     re, ra      read enable and address for this port
//     rd_word     array word at ra (combinational from the array)
//     rd_par      stored parity bits at ra
//     do_, dvld   registered read data and its valid flag
//     err         parity mismatch on the data currently in do_
//     err_addr    address that do_ was read from
module array_rdport_chk
  import array_par_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32,
  parameter int PARGRP  = 8,
  parameter int NG      = WIDTH / PARGRP
) (
  input  logic               wclk,
  input  logic               rst_,
  input  logic               re,
  input  logic [ADDRBIT-1:0] ra,
  input  logic [WIDTH-1:0]   rd_word,
  input  logic [NG-1:0]      rd_par,
  output logic [WIDTH-1:0]   do_,
  output logic               dvld,
  output logic               err,
  output logic [ADDRBIT-1:0] err_addr
);

  logic          in_rng;
  logic          rng_q;
  logic [NG-1:0] par_q;
  logic [NG-1:0] chk_par;

  // Extra top bit keeps the compare meaningful when DEPTH == 2**ADDRBIT.
  assign in_rng = {1'b0, ra} < (ADDRBIT+1)'(DEPTH);

  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      do_      <= '0;
      dvld     <= 1'b0;
      par_q    <= '0;
      rng_q    <= 1'b0;
      err_addr <= '0;
    end else begin
      dvld <= re;
      if (re) begin
        err_addr <= ra;
        rng_q    <= in_rng;
        if (in_rng) begin
          do_   <= rd_word;
          par_q <= rd_par;
        end else begin
          do_   <= '0;
          par_q <= '0;
        end
      end
    end
  end

  assign chk_par = NG'(grp_parity(MAXW'(do_), WIDTH, PARGRP));

  // Out-of-range reads return zero data and are never checked.
  assign err = dvld & rng_q & (|(par_q ^ chk_par));

endmodule

// File: rtl/array_nrp_parity.sv
// array_nrp_parity
//   Register array with NRD synchronous read ports and per-group parity.
//   Ports:
//     rst_, wclk        async active-low reset, rising-edge clock
//     we, wa, di        write port
//     re, ra            per-port read enables and packed read addresses
//     do_, dvld         packed per-port read data and valid flags
//     par_ctrl          [0] clear status, [1] freeze parity, [2] inject error
//     par_err*          sticky per-port errors, first-error address and port,
//                       saturating count of erroring cycles
module array_nrp_parity
  import array_par_pkg::*;
#(
  parameter int ADDRBIT = 9,
  parameter int DEPTH   = 512,
  parameter int WIDTH   = 32,
  parameter int PARGRP  = 8,
  parameter int NRD     = 4,
  parameter int ERRCNTW = 8
) (
  input  logic                     rst_,
  input  logic                     wclk,
  input  logic                     we,
  input  logic [ADDRBIT-1:0]       wa,
  input  logic [WIDTH-1:0]         di,
  input  logic [NRD-1:0]           re,
  input  logic [NRD*ADDRBIT-1:0]   ra,
  output logic [NRD*WIDTH-1:0]     do_,
  output logic [NRD-1:0]           dvld,
  input  logic [2:0]               par_ctrl,
  output logic                     par_err,
  output logic [NRD-1:0]           par_err_port,
  output logic [ADDRBIT-1:0]       par_err_addr,
  output logic [PIDW-1:0]          par_err_pid,
  output logic [ERRCNTW-1:0]       par_err_cnt
);

  localparam int NG = WIDTH / PARGRP;

  logic [WIDTH-1:0]   mem     [DEPTH];
  logic [NG-1:0]      par_mem [DEPTH];
  logic [NG-1:0]      wpar;
  logic               wa_ok;
  logic [NRD-1:0]     err_v;
  logic [ADDRBIT-1:0] err_addr_v [NRD];
  logic [ADDRBIT-1:0] first_addr;
  logic [PIDW-1:0]    first_pid;
  logic               captured;

  assign wa_ok = {1'b0, wa} < (ADDRBIT+1)'(DEPTH);
  assign wpar  = NG'(grp_parity(MAXW'(di), WIDTH, PARGRP));

  // Reads see the array before this edge's write, so read-during-write
  // returns old data together with its old parity.
  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]     <= '0;
        par_mem[i] <= '0;
      end
    end else if (we && wa_ok) begin
      mem[wa] <= di;
      if (!par_ctrl[1])
        par_mem[wa] <= par_ctrl[2] ? (wpar ^ NG'(1)) : wpar;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDRBIT-1:0] ra_k;
    assign ra_k = ra[k*ADDRBIT +: ADDRBIT];

    array_rdport_chk #(
      .ADDRBIT (ADDRBIT),
      .DEPTH   (DEPTH),
      .WIDTH   (WIDTH),
      .PARGRP  (PARGRP)
    ) u_chk (
      .wclk     (wclk),
      .rst_     (rst_),
      .re       (re[k]),
      .ra       (ra_k),
      .rd_word  (mem[ra_k]),
      .rd_par   (par_mem[ra_k]),
      .do_      (do_[k*WIDTH +: WIDTH]),
      .dvld     (dvld[k]),
      .err      (err_v[k]),
      .err_addr (err_addr_v[k])
    );
  end

  // Lowest-numbered erroring port wins the capture.
  always_comb begin
    first_pid  = '0;
    first_addr = '0;
    for (int k = NRD - 1; k >= 0; k--) begin
      if (err_v[k]) begin
        first_pid  = PIDW'(k);
        first_addr = err_addr_v[k];
      end
    end
  end

  always_ff @(posedge wclk or negedge rst_) begin
    if (!rst_) begin
      par_err_port <= '0;
      par_err_addr <= '0;
      par_err_pid  <= '0;
      par_err_cnt  <= '0;
      captured     <= 1'b0;
    end else if (par_ctrl[0]) begin
      par_err_port <= '0;
      par_err_addr <= '0;
      par_err_pid  <= '0;
      par_err_cnt  <= '0;
      captured     <= 1'b0;
    end else begin
      par_err_port <= par_err_port | err_v;
      if (|err_v) begin
        if (par_err_cnt != '1)
          par_err_cnt <= par_err_cnt + 1'b1;
        if (!captured) begin
          par_err_addr <= first_addr;
          par_err_pid  <= first_pid;
          captured     <= 1'b1;
        end
      end
    end
  end

  assign par_err = |par_err_port;

endmodule

// File: tb/tb_array_nrp_parity.sv
module tb_array_nrp_parity;

  localparam int ADDRBIT = 9;
  localparam int DEPTH   = 500;
  localparam int WIDTH   = 32;
  localparam int NRD     = 4;
  localparam int ERRCNTW = 2;

  logic                   rst_;
  logic                   wclk;
  logic                   we;
  logic [ADDRBIT-1:0]     wa;
  logic [WIDTH-1:0]       di;
  logic [NRD-1:0]         re;
  logic [NRD*ADDRBIT-1:0] ra;
  logic [NRD*WIDTH-1:0]   do_;
  logic [NRD-1:0]         dvld;
  logic [2:0]             par_ctrl;
  logic                   par_err;
  logic [NRD-1:0]         par_err_port;
  logic [ADDRBIT-1:0]     par_err_addr;
  logic [3:0]             par_err_pid;
  logic [ERRCNTW-1:0]     par_err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  array_nrp_parity #(
    .ADDRBIT (ADDRBIT),
    .DEPTH   (DEPTH),
    .WIDTH   (WIDTH),
    .PARGRP  (8),
    .NRD     (NRD),
    .ERRCNTW (ERRCNTW)
  ) dut (
    .rst_         (rst_),
    .wclk         (wclk),
    .we           (we),
    .wa           (wa),
    .di           (di),
    .re           (re),
    .ra           (ra),
    .do_          (do_),
    .dvld         (dvld),
    .par_ctrl     (par_ctrl),
    .par_err      (par_err),
    .par_err_port (par_err_port),
    .par_err_addr (par_err_addr),
    .par_err_pid  (par_err_pid),
    .par_err_cnt  (par_err_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_ra(input int k, input logic [ADDRBIT-1:0] a);
    ra[k*ADDRBIT +: ADDRBIT] = a;
  endtask

  function automatic logic [WIDTH-1:0] get_do(input int k);
    return do_[k*WIDTH +: WIDTH];
  endfunction

  task automatic clear_status();
    par_ctrl = 3'b001;
    tick();
    par_ctrl = 3'b000;
  endtask

  task automatic chk_status(input string tag, input logic [3:0] port,
                            input logic [8:0] addr, input logic [3:0] pid,
                            input logic [1:0] cnt);
    chk({tag, ".port"}, 64'(par_err_port), 64'(port));
    chk({tag, ".err"},  64'(par_err),      64'(|port));
    chk({tag, ".addr"}, 64'(par_err_addr), 64'(addr));
    chk({tag, ".pid"},  64'(par_err_pid),  64'(pid));
    chk({tag, ".cnt"},  64'(par_err_cnt),  64'(cnt));
  endtask

  initial begin
    rst_ = 1'b0; we = 1'b0; wa = '0; di = '0; re = '0; ra = '0; par_ctrl = 3'b000;
    #12;
    chk("rst.dvld", 64'(dvld), 64'h0);
    chk("rst.do",   64'(do_),  64'h0);
    chk_status("rst", 4'b0000, 9'd0, 4'd0, 2'd0);
    rst_ = 1'b1;
    tick();
    chk("post_rst.dvld", 64'(dvld), 64'h0);

    // reads of cleared array on all ports
    re = 4'hF;
    for (int k = 0; k < NRD; k++) set_ra(k, 9'(k));
    tick();
    chk("rd0.dvld", 64'(dvld), 64'hF);
    chk("rd0.do",   64'(do_),  64'h0);
    re = 4'h0;
    tick();
    chk("rd0.dvld_off", 64'(dvld), 64'h0);
    chk("rd0.perr",     64'(par_err), 64'h0);

    // plain write then read on port 2
    we = 1'b1; wa = 9'd5; di = 32'hA5A5_0F0F;
    tick();
    we = 1'b0; re = 4'b0100; set_ra(2, 9'd5);
    tick();
    chk("wr5.do2",  64'(get_do(2)), 64'hA5A5_0F0F);
    chk("wr5.dvld", 64'(dvld),      64'h4);
    re = 4'b0000;
    tick();
    chk("wr5.hold", 64'(get_do(2)), 64'hA5A5_0F0F);
    chk("wr5.perr", 64'(par_err),   64'h0);

    // read-during-write returns old data
    we = 1'b1; wa = 9'd5; di = 32'h1234_5678; re = 4'b0100;
    tick();
    chk("rdw.do2", 64'(get_do(2)), 64'hA5A5_0F0F);
    we = 1'b0;
    tick();
    chk("rdw.new",  64'(get_do(2)), 64'h1234_5678);
    chk("rdw.perr", 64'(par_err),   64'h0);
    re = 4'b0000;
    tick();
    chk("rdw.perr2", 64'(par_err), 64'h0);

    // injected error on addr 7, read on port 1
    par_ctrl = 3'b100; we = 1'b1; wa = 9'd7; di = 32'h1;
    tick();
    par_ctrl = 3'b000; we = 1'b0; re = 4'b0010; set_ra(1, 9'd7);
    tick();
    chk("inj.do1", 64'(get_do(1)), 64'h1);
    chk("inj.early", 64'(par_err), 64'h0);
    re = 4'b0000;
    tick();
    chk_status("inj", 4'b0010, 9'd7, 4'd1, 2'd1);

    // two ports at once after clear, then a later port 0
    clear_status();
    chk_status("clr", 4'b0000, 9'd0, 4'd0, 2'd0);
    re = 4'b1010; set_ra(3, 9'd7); set_ra(1, 9'd7);
    tick();
    re = 4'b0000;
    tick();
    chk_status("dual", 4'b1010, 9'd7, 4'd1, 2'd1);
    re = 4'b0001; set_ra(0, 9'd7);
    tick();
    re = 4'b0000;
    tick();
    chk_status("late0", 4'b1011, 9'd7, 4'd1, 2'd2);

    // frozen parity on addr 9, clear colliding with the error
    clear_status();
    we = 1'b1; wa = 9'd9; di = 32'h3;
    tick();
    par_ctrl = 3'b010; di = 32'h1;
    tick();
    par_ctrl = 3'b000; we = 1'b0; re = 4'b0001; set_ra(0, 9'd9);
    tick();
    chk("frz.do0", 64'(get_do(0)), 64'h1);
    re = 4'b0000; par_ctrl = 3'b001;
    tick();
    par_ctrl = 3'b000;
    chk_status("clrwin", 4'b0000, 9'd0, 4'd0, 2'd0);
    // error in the first cycle after clear deasserts is kept
    re = 4'b0001; par_ctrl = 3'b001;
    tick();
    re = 4'b0000; par_ctrl = 3'b000;
    tick();
    chk_status("postclr", 4'b0001, 9'd9, 4'd0, 2'd1);

    // counter saturation
    clear_status();
    re = 4'b0001; set_ra(0, 9'd9);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("sat%0d", i), 64'(par_err_cnt), 64'((i - 1 > 3) ? 3 : i - 1));
    end
    re = 4'b0000;
    tick();
    chk("sat.final", 64'(par_err_cnt), 64'd3);

    // out-of-range read on port 3 (held 0x1 from addr 7)
    clear_status();
    re = 4'b1000; set_ra(3, 9'(DEPTH));
    tick();
    chk("oor.do3",  64'(get_do(3)), 64'h0);
    chk("oor.dvld", 64'(dvld),      64'h8);
    re = 4'b0000;
    tick();
    chk("oor.perr", 64'(par_err), 64'h0);

    // async reset mid-operation
    re = 4'hF;
    for (int k = 0; k < NRD; k++) set_ra(k, 9'd5);
    tick();
    chk("arst.pre", 64'(get_do(0)), 64'h1234_5678);
    #2 rst_ = 1'b0;
    #1;
    chk("arst.dvld", 64'(dvld), 64'h0);
    chk("arst.do",   64'(do_),  64'h0);
    re = 4'h0;
    #1 rst_ = 1'b1;
    tick();
    chk("arst.rel_dvld", 64'(dvld), 64'h0);
    re = 4'b0001; set_ra(0, 9'd5);
    tick();
    chk("arst.mem", 64'(get_do(0)), 64'h0);
    re = 4'b0000;
    tick();
    chk("arst.perr", 64'(par_err), 64'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
